// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL wrapper / downstream domains.
// The sw_reset request exists only when PLL_SEQ_SW_RESET_EN is defined.
`timescale 1ns/1ps
interface pll_reset_sequencer_if #(
  parameter int NUM_CHANNELS = 2
);
  logic                    pll_locked;
  logic                    pll_rst;
  logic [NUM_CHANNELS-1:0] chan_rst;
  logic                    ready;
  logic                    lock_lost;
  logic [7:0]              retry_count;
`ifdef PLL_SEQ_SW_RESET_EN
  logic                    sw_reset;

  modport master (
    input  pll_locked, sw_reset,
    output pll_rst, chan_rst, ready, lock_lost, retry_count
  );

  modport slave (
    output pll_locked, sw_reset,
    input  pll_rst, chan_rst, ready, lock_lost, retry_count
  );
`else
  modport master (
    input  pll_locked,
    output pll_rst, chan_rst, ready, lock_lost, retry_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, chan_rst, ready, lock_lost, retry_count
  );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies lock, releases channel resets staggered.
// Define PLL_SEQ_SW_RESET_EN to add a synchronous software restart input (sw_reset).
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int NUM_CHANNELS        = 2,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8
) (
  input logic                   refclk,
  input logic                   rst,
  pll_reset_sequencer_if.master seq
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                max2(LOCK_STABLE_CYCLES, STAGGER_CYCLES));
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pll_rst_q, pll_rst_d;
  logic [NUM_CHANNELS-1:0] chan_q, chan_d;
  logic                    ready_q, ready_d;
  logic                    lost_q, lost_d;
  logic [7:0]              retry_q, retry_d;

  logic [1:0]              rst_sync;
  logic                    int_rst;
  logic [SYNC_STAGES-1:0]  lk_sync;
  logic                    lk;
  logic                    sw_req;

`ifdef PLL_SEQ_SW_RESET_EN
  assign sw_req = seq.sw_reset;
`else
  assign sw_req = 1'b0;
`endif

  // Reset asserts immediately but is released only on a refclk edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign int_rst = rst_sync[1];

  always_ff @(posedge refclk or posedge int_rst) begin
    if (int_rst) lk_sync <= '0;
    else         lk_sync <= {lk_sync[SYNC_STAGES-2:0], seq.pll_locked};
  end

  assign lk = lk_sync[SYNC_STAGES-1];

  always_ff @(posedge refclk or posedge int_rst) begin
    if (int_rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      chan_q    <= '1;
      ready_q   <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      chan_q    <= chan_d;
      ready_q   <= ready_d;
      lost_q    <= lost_d;
      retry_q   <= retry_d;
    end
  end

  // One shared counter serves every state; it is cleared on each state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pll_rst_d = pll_rst_q;
    chan_d    = chan_q;
    ready_d   = ready_q;
    lost_d    = 1'b0;
    retry_d   = retry_q;

    if (sw_req) begin
      state_d   = PLL_RESET;
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      chan_d    = '1;
      ready_d   = 1'b0;
      lost_d    = ready_q;
    end else begin
      case (state_q)
        PLL_RESET: begin
          pll_rst_d = 1'b1;
          chan_d    = '1;
          ready_d   = 1'b0;
          if (cnt_q == RST_LAST) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = PLL_RESET;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            chan_d  = chan_q << 1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            chan_d  = '1;
          end else if (chan_q == '0) begin
            state_d = RUN;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else if (cnt_q == STAGGER_LAST) begin
            cnt_d  = '0;
            chan_d = chan_q << 1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            state_d   = PLL_RESET;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            chan_d    = '1;
            ready_d   = 1'b0;
            lost_d    = 1'b1;
          end
        end
        default: begin
          state_d   = PLL_RESET;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          chan_d    = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  assign seq.pll_rst     = pll_rst_q;
  assign seq.chan_rst    = chan_q;
  assign seq.ready       = ready_q;
  assign seq.lock_lost   = lost_q;
  assign seq.retry_count = retry_q;

endmodule
